// File: rtl/am_demod.sv
// am_demod: envelope-detector AM demodulator on a Q1.13 sample bus.
// Full-wave rectifies accepted samples, integrates and dumps over
// 2^DECIM_LOG2 accepted samples, removes the carrier DC level with a
// leaky integrator and emits a gain-scaled, saturated Q1.13 audio sample.
// Optional feature macro: AM_DEMOD_DC_BLOCK_EN (DC tracker present when
// defined; otherwise the DC estimate is constant zero).
//
// Handshake: a sample is accepted on every rising edge where en and
// in_valid are both high; there is no backpressure. out_valid is a
// one-cycle pulse marking new env_q13/audio_q13 values; there is no
// ready from the sink, so the consumer must take the sample on the pulse.
//
// Operating mode: RUN is simply en high, IDLE is en low. Dropping en
// clears the block in progress, the pending emit and the settle count.
module am_demod #(
  parameter int DECIM_LOG2    = 5,
  parameter int DC_SHIFT      = 6,
  parameter int GAIN_SHIFT    = 1,
  parameter int SETTLE_BLOCKS = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic signed [13:0] rf_q13,
  output logic               out_valid,
  output logic signed [13:0] env_q13,
  output logic signed [13:0] audio_q13,
  output logic               settled
);

  localparam int ACC_W = 13 + DECIM_LOG2;
  localparam int DC_W  = 14 + DC_SHIFT;
  localparam int SH_W  = 15 + GAIN_SHIFT;

  localparam logic [DECIM_LOG2-1:0] CNT_LAST   = '1;
  localparam logic [15:0]           SETTLE_MAX = 16'(SETTLE_BLOCKS);
  localparam logic signed [SH_W-1:0] SAT_HI    = SH_W'(8191);
  localparam logic signed [SH_W-1:0] SAT_LO    = -SH_W'(8192);

  logic                  accept;
  logic                  emit_fire;
  logic [12:0]           mag;
  logic signed [13:0]    rf_neg;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_next;
  logic [ACC_W-1:0]      block_sum;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  emit_pend;
  logic [15:0]           settle_cnt;
  logic [12:0]           avg;
  logic signed [13:0]    dc_est;
  logic signed [14:0]    diff;
  logic signed [SH_W-1:0] diff_ext;
  logic signed [SH_W-1:0] scaled;
  logic signed [13:0]    audio_sat;

  assign accept    = en && in_valid;
  assign emit_fire = en && emit_pend;

  // Full-wave rectification; -8192 has no positive twin, so it clamps to 8191.
  assign rf_neg = -rf_q13;
  always_comb begin
    mag = rf_q13[12:0];
    if (rf_q13 == 14'sh2000) begin
      mag = 13'h1fff;
    end else if (rf_q13[13]) begin
      mag = rf_neg[12:0];
    end
  end

  // Running block sum including the sample being accepted this cycle.
  assign acc_next = acc + ACC_W'(mag);

  // Block mean: the sum of 2^DECIM_LOG2 13-bit values, truncated back to 13 bits.
  assign avg = block_sum[ACC_W-1:DECIM_LOG2];

`ifdef AM_DEMOD_DC_BLOCK_EN
  logic signed [DC_W-1:0] dc_acc;
  logic signed [DC_W-1:0] avg_dc;
  logic signed [DC_W-1:0] est_dc;

  // Arithmetic shift by DC_SHIFT leaves exactly the top 14 bits.
  assign dc_est = dc_acc[DC_W-1:DC_SHIFT];
  assign avg_dc = $signed({{(DC_W-13){1'b0}}, avg});
  assign est_dc = DC_W'(dc_est);

  // Leaky integrator tracking the carrier level; held while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_acc <= '0;
    end else if (emit_fire) begin
      dc_acc <= dc_acc + avg_dc - est_dc;
    end
  end
`else
  assign dc_est = '0;
`endif

  // DC removal, gain and saturation to the Q1.13 range.
  assign diff     = $signed({2'b00, avg}) - $signed({dc_est[13], dc_est});
  assign diff_ext = SH_W'(diff);
  assign scaled   = diff_ext <<< GAIN_SHIFT;
  always_comb begin
    audio_sat = scaled[13:0];
    if (scaled > SAT_HI) begin
      audio_sat = 14'sh1fff;
    end else if (scaled < SAT_LO) begin
      audio_sat = 14'sh2000;
    end
  end

  // Integrate-and-dump, emit stage and settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      block_sum  <= '0;
      emit_pend  <= 1'b0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      env_q13    <= '0;
      audio_q13  <= '0;
    end else if (!en) begin
      acc        <= '0;
      cnt        <= '0;
      emit_pend  <= 1'b0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
    end else begin
      emit_pend <= 1'b0;
      out_valid <= 1'b0;
      if (accept) begin
        if (cnt == CNT_LAST) begin
          block_sum <= acc_next;
          acc       <= '0;
          cnt       <= '0;
          emit_pend <= 1'b1;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
      if (emit_fire) begin
        env_q13   <= $signed({1'b0, avg});
        audio_q13 <= audio_sat;
        out_valid <= 1'b1;
        if (settle_cnt != SETTLE_MAX) begin
          settle_cnt <= settle_cnt + 16'd1;
        end
      end
    end
  end

  assign settled = (settle_cnt == SETTLE_MAX);

endmodule

// File: doc/am_demod.md
# am_demod

Envelope-detector AM demodulator, the receive-side counterpart of the DSB-FC modulator on the same Q1.13 sample bus. Full-wave-rectifies a valid-qualified Q1.13 RF sample stream, integrates and dumps over a power-of-two block to form a decimated envelope, removes the carrier DC level with a leaky integrator, and emits a gain-scaled, saturated Q1.13 audio sample. Sits between the ADC/loopback sample source and the audio sink.

## Interface
- `DECIM_LOG2`, 5: block length is 2^DECIM_LOG2 accepted samples (1..10).
- `DC_SHIFT`, 6: DC tracker time constant, 2^DC_SHIFT output blocks (2..12).
- `GAIN_SHIFT`, 1: audio gain is 2^GAIN_SHIFT (0..4).
- `SETTLE_BLOCKS`, 256: output blocks before `settled` asserts (1..65535).
- `clk`  in  1  sample clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; low clears the block in progress.
- `in_valid`  in  1  `rf_q13` is valid this cycle; may be high every cycle.
- `rf_q13`  in  14 signed  RF sample, Q1.13.
- `out_valid`  out  1  one-cycle pulse; `env_q13`/`audio_q13` updated.
- `env_q13`  out  14 signed  block-mean rectified magnitude, 0..8191.
- `audio_q13`  out  14 signed  DC-removed, gain-scaled audio, Q1.13.
- `settled`  out  1  high once `SETTLE_BLOCKS` blocks emitted since reset or `en` rise.

## Operation
- States: IDLE (`en` low) and RUN (`en` high). IDLE->RUN on `en` high; RUN->IDLE on `en` low; either -> IDLE on `rst`.
- Accept: sample accepted on an edge with `en` && `in_valid`. No backpressure; acceptance is never stalled, including during an emit cycle.
- Rectify: mag = |rf_q13|, 13-bit unsigned; -8192 saturates to 8191.
- Integrate: accumulator of 13+DECIM_LOG2 bits, sample counter of DECIM_LOG2 bits. On the accept edge of the 2^DECIM_LOG2-th sample, block_sum <= acc + mag, acc <= 0, counter wraps to 0, emit flag set.
- Emit stage, on the edge following block capture: avg = block_sum >> DECIM_LOG2, truncating; env_q13 <= avg. dc_est = dc_acc >>> DC_SHIFT; diff = avg - dc_est (15-bit signed); audio_q13 <= sat14(diff <<< GAIN_SHIFT), clamping to [-8192, 8191]; dc_acc <= dc_acc + avg - dc_est, with dc_acc being 14+DC_SHIFT bits signed and never overflowing, because avg <= 8191.
- Settle counter increments per emit, saturates at SETTLE_BLOCKS; `settled` = (count == SETTLE_BLOCKS).
- `en` low: acc, counter, pending emit flag and settle counter clear; `settled` low; `env_q13`, `audio_q13` and `dc_acc` hold their values, so the DC estimate is kept across pauses. A partial block is discarded.
- `en` falling on the same edge as a block capture: capture is discarded, no emit.

## Timing
- Reset values: `out_valid`=0, `env_q13`=0, `audio_q13`=0, `settled`=0; acc, counter, block_sum, dc_acc and settle counter all 0.
- Latency: `out_valid` is high for exactly the one cycle after the emit edge, i.e. asserted after the 2nd rising edge counting the edge that accepted the block's final sample. Outputs are registered.
- Minimum spacing between `out_valid` pulses: 2^DECIM_LOG2 cycles.
- `rst` mid-block or during the emit cycle: that emit is suppressed and all state returns to reset values on that edge.

## Configuration
- `AM_DEMOD_DC_BLOCK_EN` defined: DC tracker active as described.
- `AM_DEMOD_DC_BLOCK_EN` undefined: dc_acc is not implemented, dc_est is constant 0, and audio_q13 = sat14(avg <<< GAIN_SHIFT). The `env_q13`, `settled` and timing behaviour are unchanged.

## Test plan
All scenarios use default parameters and `AM_DEMOD_DC_BLOCK_EN` defined, unless noted.
- Reset, then 32 valid samples of +4096 every cycle -> a single `out_valid` pulse 1 cycle after the 32nd accept, with `env_q13`=4096 and `audio_q13`=8191 (saturated: diff 4096 << 1).
- 32 samples of -8192 -> `env_q13`=8191.
- Repeating sequence 0, 5657, 8000, 5657, 0, -5657, -8000, -5657 with continuous valid -> `env_q13`=4828 every block, and `out_valid` pulses exactly every 32 cycles.
- Constant +4096 for 1024 blocks -> |`audio_q13`| <= 2 and `env_q13`=4096. `settled` rises on the 256th emit and stays high.
- `en` dropped after 20 of 32 samples, then raised and 32 more samples of +4096 -> no emit for the partial block, and the next emit occurs exactly 32 accepts after `en` rises. `settled` restarts from 0.
- Gaps in `in_valid` (valid every 3rd cycle) -> emit after the 32nd accepted sample, not the 32nd cycle. With the macro undefined, constant +4096 gives `audio_q13`=8191 on every block.
